// File: rtl/quad_enc_counter.sv
// Quadrature encoder decoder: 2-flop sync, per-channel debounce, x4 transition decode, position counter.
// Define QENC_SAT_EN to make q saturate at 0 and 2^CNT_W-1 instead of wrapping.
module quad_enc_counter #(
  parameter int CNT_W      = 4,
  parameter int DEB_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clr,
  output logic [CNT_W-1:0] q,
  output logic             dir,
  output logic             step,
  output logic             err
);

  localparam logic [15:0]      DEB_LAST = 16'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] Q_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
`ifdef QENC_SAT_EN
  localparam logic [CNT_W-1:0] Q_MAX    = {CNT_W{1'b1}};
`endif

  logic [1:0] raw;
  logic [1:0] filt;

  assign raw = {enc_a, enc_b};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic        s1_reg;
      logic        s2_reg;
      logic        filt_reg;
      logic [15:0] cnt_reg;

      // Any return of s2 to the filtered value restarts the stability count.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          s1_reg   <= 1'b0;
          s2_reg   <= 1'b0;
          filt_reg <= 1'b0;
          cnt_reg  <= '0;
        end else begin
          s1_reg <= raw[gi];
          s2_reg <= s1_reg;
          if (s2_reg == filt_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            filt_reg <= s2_reg;
            cnt_reg  <= '0;
          end else begin
            cnt_reg <= cnt_reg + 16'd1;
          end
        end
      end

      assign filt[gi] = filt_reg;
    end
  endgenerate

  logic [1:0]       prev_reg;
  logic [CNT_W-1:0] q_reg, q_next;
  logic             dir_reg, dir_next;
  logic             step_reg, step_next;
  logic             err_reg, err_next;
  logic [1:0]       pos_cur, pos_prev, delta;

  // Gray position along the up sequence 00,01,11,10; a delta of 1 is up, 3 down, 2 illegal.
  assign pos_cur  = {filt[1], filt[1] ^ filt[0]};
  assign pos_prev = {prev_reg[1], prev_reg[1] ^ prev_reg[0]};
  assign delta    = pos_cur - pos_prev;

  always_comb begin
    q_next    = q_reg;
    dir_next  = dir_reg;
    step_next = 1'b0;
    err_next  = 1'b0;
    case (delta)
      2'd1: begin
        dir_next = 1'b1;
`ifdef QENC_SAT_EN
        if (q_reg != Q_MAX) begin
          q_next    = q_reg + Q_ONE;
          step_next = 1'b1;
        end
`else
        q_next    = q_reg + Q_ONE;
        step_next = 1'b1;
`endif
      end
      2'd3: begin
        dir_next = 1'b0;
`ifdef QENC_SAT_EN
        if (q_reg != '0) begin
          q_next    = q_reg - Q_ONE;
          step_next = 1'b1;
        end
`else
        q_next    = q_reg - Q_ONE;
        step_next = 1'b1;
`endif
      end
      2'd2:    err_next = 1'b1;
      default: ;
    endcase
    // Clear wins over a same-cycle step; the step is consumed, not deferred.
    if (clr) begin
      q_next    = '0;
      step_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_reg <= 2'b00;
      q_reg    <= '0;
      dir_reg  <= 1'b0;
      step_reg <= 1'b0;
      err_reg  <= 1'b0;
    end else begin
      prev_reg <= filt;
      q_reg    <= q_next;
      dir_reg  <= dir_next;
      step_reg <= step_next;
      err_reg  <= err_next;
    end
  end

  assign q    = q_reg;
  assign dir  = dir_reg;
  assign step = step_reg;
  assign err  = err_reg;

endmodule

// File: tb/tb_quad_enc_counter.sv
// Directed bench for quad_enc_counter with DEB_CYCLES=4, CNT_W=4 (wrap or QENC_SAT_EN build).
module tb_quad_enc_counter;

  logic       clk;
  logic       reset;
  logic       enc_a;
  logic       enc_b;
  logic       clr;
  logic [3:0] q;
  logic       dir;
  logic       step;
  logic       err;

  int tests_run = 0;
  int tests_failed = 0;
  int step_total = 0;
  int err_total = 0;
  int s0;
  int e0;

  quad_enc_counter #(.CNT_W(4), .DEB_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .enc_a (enc_a),
    .enc_b (enc_b),
    .clr   (clr),
    .q     (q),
    .dir   (dir),
    .step  (step),
    .err   (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count high cycles of each pulse so a stuck pulse shows up as an excess.
  always @(negedge clk) begin
    if (step === 1'b1) step_total++;
    if (err === 1'b1) err_total++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic drive_ab(input logic a, input logic b);
    @(negedge clk);
    enc_a = a;
    enc_b = b;
    $display("[TB] drive ab=%b%b q=%0d dir=%0d", a, b, q, dir);
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic up_phase(input logic a, input logic b, input int old_q, input int new_q);
    drive_ab(a, b);
    edges(6);
    check("up_hold_edge6", q, old_q);
    check("up_step_edge6", step, 0);
    edges(1);
    check("up_q_edge7", q, new_q);
    check("up_step_edge7", step, 1);
    check("up_dir", dir, 1);
    edges(1);
    check("up_step_edge8", step, 0);
    edges(2);
  endtask

  initial begin
    reset = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    clr   = 1'b0;
    #12;
    check("rst_q", q, 0);
    check("rst_dir", dir, 0);
    check("rst_step", step, 0);
    check("rst_err", err, 0);
    @(negedge clk);
    reset = 1'b1;
    s0 = step_total;
    e0 = err_total;
    edges(20);
    check("idle_q", q, 0);
    check("idle_step_cnt", step_total - s0, 0);
    check("idle_err_cnt", err_total - e0, 0);

    // one down step from zero
    s0 = step_total;
    drive_ab(1'b1, 1'b0);
    edges(6);
    check("down_hold", q, 0);
    edges(1);
`ifdef QENC_SAT_EN
    check("down_q_sat", q, 0);
    check("down_step_sat", step, 0);
`else
    check("down_q_wrap", q, 15);
    check("down_step", step, 1);
`endif
    check("down_dir", dir, 0);
    edges(3);
`ifdef QENC_SAT_EN
    check("down_step_cnt", step_total - s0, 0);
`else
    check("down_step_cnt", step_total - s0, 1);
`endif

    // back up 10->00 wraps max to zero (or leaves sat build at 1)
    drive_ab(1'b0, 1'b0);
    edges(10);
`ifdef QENC_SAT_EN
    check("wrap_up_q", q, 1);
`else
    check("wrap_up_q", q, 0);
`endif
    check("wrap_up_dir", dir, 1);

    @(negedge clk);
    clr = 1'b1;
    edges(1);
    check("clr_q", q, 0);
    check("clr_step", step, 0);
    @(negedge clk);
    clr = 1'b0;
    check("clr_dir_kept", dir, 1);

    up_phase(1'b0, 1'b1, 0, 1);
    up_phase(1'b1, 1'b1, 1, 2);
    up_phase(1'b1, 1'b0, 2, 3);
    up_phase(1'b0, 1'b0, 3, 4);

    // bounce on A shorter than the filter window
    s0 = step_total;
    e0 = err_total;
    for (int i = 0; i < 5; i++) begin
      drive_ab(1'b1, 1'b0);
      @(negedge clk);
      drive_ab(1'b0, 1'b0);
      @(negedge clk);
    end
    edges(10);
    check("bounce_q", q, 4);
    check("bounce_step_cnt", step_total - s0, 0);
    check("bounce_err_cnt", err_total - e0, 0);

    // both channels together is illegal
    s0 = step_total;
    e0 = err_total;
    drive_ab(1'b1, 1'b1);
    edges(10);
    check("illegal_err_cnt", err_total - e0, 1);
    check("illegal_step_cnt", step_total - s0, 0);
    check("illegal_q", q, 4);
    check("illegal_dir", dir, 1);

    drive_ab(1'b1, 1'b0);
    edges(10);
    check("pre_clr_q", q, 5);

    // clear coincident with an up step
    s0 = step_total;
    drive_ab(1'b0, 1'b0);
    edges(6);
    check("clr_coin_hold", q, 5);
    @(negedge clk);
    clr = 1'b1;
    edges(1);
    check("clr_coin_q", q, 0);
    check("clr_coin_step", step, 0);
    @(negedge clk);
    clr = 1'b0;
    edges(10);
    check("clr_coin_after_q", q, 0);
    check("clr_coin_step_cnt", step_total - s0, 0);
    check("clr_coin_dir", dir, 1);

    // reset mid-debounce
    drive_ab(1'b0, 1'b1);
    edges(10);
    check("pre_rst_q", q, 1);
    drive_ab(1'b1, 1'b1);
    edges(4);
    reset = 1'b0;
    #1;
    check("mid_rst_q", q, 0);
    check("mid_rst_dir", dir, 0);
    enc_a = 1'b0;
    enc_b = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    $display("[TB] release reset ab=01");
    edges(6);
    check("post_rst_hold", q, 0);
    edges(1);
    check("post_rst_q", q, 1);
    check("post_rst_step", step, 1);
    check("post_rst_dir", dir, 1);
    edges(3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/quad_enc_counter.md
Name: quad_enc_counter

Overview:
- Decodes a two-channel quadrature rotary encoder on board pins into a CNT_W-bit position count for the LEDs.
- Provides direction and step indication.
- Input-side counterpart to the free-running up/down LED counters: encoder motion sets the count direction and count events.
- Contains a per-channel synchronizer, a per-channel debounce filter, a quadrature transition decoder and a wrap-around position counter.

Parameters:
- CNT_W, 4, width of position count q.
- DEB_CYCLES, 50000, consecutive stable cycles needed before a debounced channel changes. Range 2..65535. Set to 4 in simulation.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous active-low reset (0 = reset).
- enc_a  input  1  encoder channel A, raw and asynchronous.
- enc_b  input  1  encoder channel B, raw and asynchronous.
- clr  input  1  synchronous active-high count clear; already synchronous to clk.
- q  output  CNT_W  position count.
- dir  output  1  direction of last valid step (1 = up, 0 = down).
- step  output  1  one-cycle pulse on every count change.
- err  output  1  one-cycle pulse on an illegal quadrature transition.

Behaviour:
- Reset (reset = 0, async) clears all state:
  - q = 0, dir = 0, step = 0, err = 0.
  - Sync flops = 0, filtered channels = 0, previous-state register = 2'b00, debounce counters = 0.
  - No output glitches after release.
- Synchronizer: each channel passes through 2 flops (s1 then s2).
- Debounce, per channel, with filt, a 16-bit counter cnt and sync value s2:
  - s2 == filt: cnt <= 0.
  - s2 != filt and cnt == DEB_CYCLES-1: filt <= s2, cnt <= 0.
  - Otherwise: cnt <= cnt+1.
  - A bounce back to filt before expiry restarts the count.
- Decoder:
  - prev <= {filtA, filtB} every cycle.
  - cur = {filtA, filtB}; transitions are evaluated combinationally from (prev, cur), with outputs registered.
  - Up sequence: 00->01->11->10->00, i.e. x4 decoding with one count per edge.
  - Down sequence: 00->10->11->01->00.
  - cur == prev: no action.
  - Valid up step: q <= q+1, dir <= 1, step <= 1.
  - Valid down step: q <= q-1, dir <= 0, step <= 1.
  - Both bits changed (00<->11, 01<->10): q and dir unchanged, err <= 1, step <= 0.
- Arithmetic: modulo 2^CNT_W. Max+1 wraps to 0; 0-1 wraps to max. Both still pulse step.
- Latency: a raw channel change held stable updates q, dir and step at exactly clock edge DEB_CYCLES+3 after the change is first sampled (2 sync + DEB_CYCLES filter + 1 decode).
- clr:
  - q <= 0, step <= 0; dir unchanged.
  - Takes priority over a simultaneous step.
  - Filter and prev still update, so the pending step is consumed, not deferred.
  - err still pulses if the same-cycle transition is illegal.
- step and err are single-cycle pulses and are 0 in every other cycle.
- Both channels settling on the same cycle gives a 2-bit change, which is reported as err. It is not a step.
- Reset asserted mid-debounce or mid-transition: all state clears immediately. After release, the first transition is evaluated against prev = 00.

Optional Feature:
- Macro QENC_SAT_EN.
- Defined: q saturates.
  - Up step at q = 2^CNT_W-1 leaves q unchanged, with step = 0 and dir = 1.
  - Down step at q = 0 leaves q unchanged, with step = 0 and dir = 0.
- Undefined: wrap-around as specified in Behaviour.
- Latency, clr and err behaviour are identical in both builds.

Test Plan (DEB_CYCLES = 4, CNT_W = 4):
- Reset low then high, inputs 00 -> q = 0, dir = 0, step and err never high for 20 cycles.
- Drive AB 00->01->11->10->00, each phase held 10 cycles -> q = 1, 2, 3, 4. Each update lands 7 edges after the input change with a 1-cycle step. dir = 1.
- From q = 0, drive one down step 00->10 -> q = 15 with step pulse and dir = 0. With QENC_SAT_EN: q stays 0, no step.
- A toggles 0/1 every 2 cycles for 20 cycles, then rests at 0 -> q unchanged, no step, no err.
- Change A and B together 00->11, held 10 cycles -> one err pulse, q unchanged. Then clr high for 1 cycle at q = 5 coincident with an up step -> q = 0, step = 0.
- Assert reset mid-debounce (cnt = 2) -> q = 0 immediately. After release, an input held at 01 for 7 edges -> q = 1.
